// File: rtl/egg_timer_controller.sv
// egg_timer_controller: button-driven mode FSM that edits the BCD setting and sequences load/run/pause/alarm
module egg_timer_controller #(
   parameter int ALARM_CYCLES = 250000000,
   parameter int GUARD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnStartStop,
   input  logic       btnSet,
   input  logic       btnDigit,
   input  logic       btnIncrement,
   input  logic       isZero,
   output logic [3:0] setting0,
   output logic [3:0] setting1,
   output logic [3:0] setting2,
   output logic [3:0] setting3,
   output logic [1:0] editDigit,
   output logic       isSetting,
   output logic       isStarting,
   output logic       isStopping,
   output logic       isRunning,
   output logic       alarm
);
   localparam int AW = $clog2(ALARM_CYCLES + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, SETTING, LOAD, RUNNING, PAUSED, ALARM} state_t;
   state_t state, nxt;
   logic [3:0] btn, prev, e;
   logic [3:0] dig [4];
   logic [AW-1:0] acnt;
   logic [GW-1:0] gcnt;
   logic e_set, e_ss, e_dig, e_inc, nonzero, fire;
   logic [3:0] lim;
   assign btn = {btnSet, btnStartStop, btnDigit, btnIncrement};
   assign e = btn & ~prev;
   assign e_set = e[3];
   assign e_ss = e[2] & ~e[3];
   assign e_dig = e[1] & ~|e[3:2];
   assign e_inc = e[0] & ~|e[3:1];
   assign nonzero = |{dig[0], dig[1], dig[2], dig[3]};
   assign fire = isZero && gcnt == '0;
   assign lim = (editDigit == 2'd1) ? 4'd5 : 4'd9;
   assign setting0 = dig[0];
   assign setting1 = dig[1];
   assign setting2 = dig[2];
   assign setting3 = dig[3];
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = e_set ? SETTING : (e_ss && nonzero) ? LOAD : IDLE;
         SETTING: nxt = e_set ? IDLE : (e_ss && nonzero) ? LOAD : SETTING;
         LOAD:    nxt = RUNNING;
         RUNNING: nxt = fire ? ALARM : e_set ? SETTING : e_ss ? PAUSED : RUNNING;
         PAUSED:  nxt = e_set ? SETTING : e_ss ? RUNNING : PAUSED;
         ALARM:   nxt = (|e || acnt == AW'(ALARM_CYCLES - 1)) ? IDLE : ALARM;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         prev <= 4'hF;
         dig <= '{default: 4'd0};
         editDigit <= 2'd0;
         acnt <= '0;
         gcnt <= '0;
         isSetting <= 1'b0;
         isStarting <= 1'b0;
         isStopping <= 1'b0;
         isRunning <= 1'b0;
         alarm <= 1'b0;
      end else begin
         prev <= btn;
         state <= nxt;
         isSetting <= nxt == SETTING || nxt == LOAD;
         isRunning <= nxt == RUNNING;
         alarm <= nxt == ALARM;
         isStarting <= nxt == RUNNING && state != RUNNING;
         isStopping <= state == RUNNING && nxt != RUNNING;
         gcnt <= (nxt == RUNNING && state != RUNNING) ? GW'(GUARD_CYCLES) :
                 (state == RUNNING && gcnt != '0) ? gcnt - 1'b1 : gcnt;
         // held at zero outside ALARM so every entry starts counting from 0
         acnt <= (state == ALARM) ? acnt + 1'b1 : '0;
         if (state == SETTING && e_dig) editDigit <= editDigit + 2'd1;
         if (state == SETTING && e_inc) dig[editDigit] <= (dig[editDigit] == lim) ? 4'd0 : dig[editDigit] + 4'd1;
         if (nxt == SETTING && state != SETTING) editDigit <= 2'd0;
      end
   end
endmodule

// File: tb/tb_egg_timer_controller.sv
// tb_egg_timer_controller: directed scenario bench for egg_timer_controller
module tb_egg_timer_controller;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [3:0] b = 4'b0;
   logic isZero = 1'b0;
   logic [3:0] setting0, setting1, setting2, setting3;
   logic [1:0] editDigit;
   logic isSetting, isStarting, isStopping, isRunning, alarm;
   int total = 0;
   int bad = 0;

   egg_timer_controller #(.ALARM_CYCLES(4), .GUARD_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .btnStartStop(b[2]), .btnSet(b[3]), .btnDigit(b[1]), .btnIncrement(b[0]),
      .isZero(isZero),
      .setting0(setting0), .setting1(setting1), .setting2(setting2), .setting3(setting3),
      .editDigit(editDigit), .isSetting(isSetting), .isStarting(isStarting),
      .isStopping(isStopping), .isRunning(isRunning), .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] v);
      b = v;
      tick();
      b = 4'b0;
      tick();
   endtask

   task automatic test_reset();
      b = 4'b1000;
      #12;
      total++; if ({isSetting, isStarting, isStopping, isRunning, alarm} !== 5'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=00000", {isSetting, isStarting, isStopping, isRunning, alarm}); end
      total++; if ({setting3, setting2, setting1, setting0, editDigit} !== 18'h0) begin bad++; $display("FAIL reset_digits got=%h exp=0", {setting3, setting2, setting1, setting0, editDigit}); end
      reset = 1'b1;
      tick();
      tick();
      total++; if (isSetting !== 1'b0) begin bad++; $display("FAIL held_set_no_edge got=%b exp=0", isSetting); end
      b = 4'b0;
      tick();
   endtask

   task automatic test_zero_start();
      b = 4'b0100;
      tick();
      total++; if ({isSetting, isStarting} !== 2'b00) begin bad++; $display("FAIL zero_start_load got=%b exp=00", {isSetting, isStarting}); end
      b = 4'b0;
      tick();
      total++; if ({isStarting, isRunning} !== 2'b00) begin bad++; $display("FAIL zero_start_run got=%b exp=00", {isStarting, isRunning}); end
   endtask

   task automatic test_setting();
      press(4'b1000);
      total++; if ({isSetting, editDigit} !== 3'b100) begin bad++; $display("FAIL enter_setting got=%b exp=100", {isSetting, editDigit}); end
      for (int i = 0; i < 7; i++) press(4'b0001);
      total++; if (setting0 !== 4'd7) begin bad++; $display("FAIL digit0_inc7 got=%0d exp=7", setting0); end
      press(4'b0010);
      for (int i = 0; i < 6; i++) press(4'b0001);
      total++; if ({editDigit, setting1} !== {2'd1, 4'd0}) begin bad++; $display("FAIL digit1_wrap got=%h exp=10", {editDigit, setting1}); end
      press(4'b0010);
      press(4'b0010);
      press(4'b0001);
      total++; if ({editDigit, setting3, setting2} !== {2'd3, 4'd1, 4'd0}) begin bad++; $display("FAIL digit3_inc got=%h exp=310", {editDigit, setting3, setting2}); end
      press(4'b0010);
      for (int i = 0; i < 3; i++) press(4'b0001);
      total++; if ({editDigit, setting0} !== {2'd0, 4'd0}) begin bad++; $display("FAIL digit0_wrap9 got=%h exp=00", {editDigit, setting0}); end
      total++; if (isSetting !== 1'b1) begin bad++; $display("FAIL still_setting got=%b exp=1", isSetting); end
   endtask

   task automatic test_start();
      isZero = 1'b1;
      b = 4'b0100;
      tick();
      total++; if ({isSetting, isStarting, isRunning} !== 3'b100) begin bad++; $display("FAIL load_cycle got=%b exp=100", {isSetting, isStarting, isRunning}); end
      b = 4'b0;
      tick();
      total++; if ({isSetting, isStarting, isRunning, alarm} !== 4'b0110) begin bad++; $display("FAIL run_entry got=%b exp=0110", {isSetting, isStarting, isRunning, alarm}); end
      tick();
      total++; if ({isStarting, isRunning, alarm} !== 3'b010) begin bad++; $display("FAIL guard1 got=%b exp=010", {isStarting, isRunning, alarm}); end
      tick();
      total++; if ({isRunning, alarm} !== 2'b10) begin bad++; $display("FAIL guard2 got=%b exp=10", {isRunning, alarm}); end
      isZero = 1'b0;
   endtask

   task automatic test_pause();
      b = 4'b0100;
      tick();
      total++; if ({isStopping, isRunning} !== 2'b10) begin bad++; $display("FAIL pause_stop got=%b exp=10", {isStopping, isRunning}); end
      b = 4'b0;
      tick();
      total++; if ({isStopping, isRunning, isSetting} !== 3'b000) begin bad++; $display("FAIL paused got=%b exp=000", {isStopping, isRunning, isSetting}); end
      b = 4'b0100;
      tick();
      total++; if ({isStarting, isRunning, isSetting} !== 3'b110) begin bad++; $display("FAIL resume got=%b exp=110", {isStarting, isRunning, isSetting}); end
      b = 4'b0;
      tick();
      total++; if ({isStarting, isRunning} !== 2'b01) begin bad++; $display("FAIL resumed got=%b exp=01", {isStarting, isRunning}); end
   endtask

   task automatic test_alarm();
      tick();
      tick();
      isZero = 1'b1;
      tick();
      total++; if ({alarm, isStopping, isRunning} !== 3'b110) begin bad++; $display("FAIL alarm_entry got=%b exp=110", {alarm, isStopping, isRunning}); end
      isZero = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         tick();
         total++; if ({alarm, isStopping} !== 2'b10) begin bad++; $display("FAIL alarm_cycle%0d got=%b exp=10", i, {alarm, isStopping}); end
      end
      tick();
      total++; if ({alarm, isRunning, isSetting} !== 3'b000) begin bad++; $display("FAIL alarm_timeout got=%b exp=000", {alarm, isRunning, isSetting}); end
      total++; if (setting3 !== 4'd1) begin bad++; $display("FAIL setting_kept got=%0d exp=1", setting3); end
   endtask

   task automatic test_alarm_cancel();
      press(4'b0100);
      tick();
      tick();
      isZero = 1'b1;
      tick();
      isZero = 1'b0;
      tick();
      total++; if (alarm !== 1'b1) begin bad++; $display("FAIL cancel_alarm2 got=%b exp=1", alarm); end
      b = 4'b0010;
      tick();
      total++; if (alarm !== 1'b0) begin bad++; $display("FAIL cancel_idle got=%b exp=0", alarm); end
      b = 4'b0;
      tick();
      total++; if ({alarm, isSetting, isRunning, editDigit} !== 5'b0) begin bad++; $display("FAIL cancel_quiet got=%b exp=00000", {alarm, isSetting, isRunning, editDigit}); end
   endtask

   task automatic test_priority();
      press(4'b0100);
      press(4'b0100);
      total++; if ({isRunning, isSetting} !== 2'b00) begin bad++; $display("FAIL prio_paused got=%b exp=00", {isRunning, isSetting}); end
      b = 4'b1100;
      tick();
      b = 4'b0;
      tick();
      total++; if ({isSetting, isRunning, isStarting} !== 3'b100) begin bad++; $display("FAIL prio_set_over_ss got=%b exp=100", {isSetting, isRunning, isStarting}); end
      press(4'b0100);
      tick();
      tick();
      isZero = 1'b1;
      b = 4'b0100;
      tick();
      total++; if ({alarm, isRunning, isStopping} !== 3'b101) begin bad++; $display("FAIL prio_zero_over_ss got=%b exp=101", {alarm, isRunning, isStopping}); end
      isZero = 1'b0;
      b = 4'b0;
      press(4'b0001);
   endtask

   task automatic test_reset_mid();
      press(4'b0100);
      tick();
      #2;
      reset = 1'b0;
      #1;
      total++; if ({isRunning, isStarting, isStopping, setting3} !== 7'b0) begin bad++; $display("FAIL async_reset got=%b exp=0000000", {isRunning, isStarting, isStopping, setting3}); end
      #2;
      reset = 1'b1;
      tick();
      total++; if ({isStopping, isStarting, isRunning} !== 3'b000) begin bad++; $display("FAIL post_reset got=%b exp=000", {isStopping, isStarting, isRunning}); end
   endtask

   initial begin
      test_reset();
      test_zero_start();
      test_setting();
      test_start();
      test_pause();
      test_alarm();
      test_alarm_cancel();
      test_priority();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/egg_timer_controller.md
# egg_timer_controller

Mode controller for the egg timer. Turns edges on four debounced push-buttons into the control strobes that drive the countdown datapath: isSetting, isStarting, isStopping and isRunning. It holds and edits the four BCD setting digits (the configuration the datapath loads), sequences load/run/pause, and raises a timed alarm when the datapath reports zero. It sits between the button front end and the running-count datapath.

## Interface
- ALARM_CYCLES, 250000000: alarm duration in clk cycles; must be ≥1.
- GUARD_CYCLES, 2: cycles after entry to RUNNING during which isZero is ignored; must be ≥2.
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserting forces every register to its reset value immediately
- btnStartStop  in  1  debounced level, synchronous to clk
- btnSet  in  1  debounced level; enter/leave setting mode
- btnDigit  in  1  debounced level; select next digit while setting
- btnIncrement  in  1  debounced level; increment selected digit
- isZero  in  1  registered all-digits-zero flag from the datapath
- setting0..setting3  out  4 each  BCD setting digits, least significant first
- editDigit  out  2  index of the digit being edited
- isSetting  out  1  datapath load enable (level)
- isStarting  out  1  one-cycle strobe; resynchronises the seconds divider
- isStopping  out  1  one-cycle strobe on leaving RUNNING
- isRunning  out  1  countdown enable (level)
- alarm  out  1  high throughout ALARM

## Operation
- Edge detect: each button has a prev register; edge = btn & ~prev. prev resets to 1, so a button held through reset produces no edge until released and pressed again.
- Edge priority in the same cycle: Set > StartStop > Digit > Increment. Only the highest-priority edge acts.
- States: IDLE, SETTING, LOAD, RUNNING, PAUSED, ALARM.
- IDLE:
  - Set goes to SETTING with editDigit=0.
  - StartStop goes to LOAD if any setting digit ≠0; otherwise it is ignored.
- SETTING:
  - Digit advances editDigit by one, modulo 4.
  - Increment adds 1 to the selected digit. Wrap limits: digit0 9→0, digit1 5→0, digit2 9→0, digit3 9→0.
  - Set goes to IDLE.
  - StartStop goes to LOAD when the setting is nonzero.
- LOAD: lasts exactly 1 cycle, then goes unconditionally to RUNNING.
- RUNNING:
  - If isZero=1 and the guard counter is 0, go to ALARM. This has priority over any button edge.
  - Otherwise, Set goes to SETTING and StartStop goes to PAUSED.
- PAUSED:
  - StartStop goes to RUNNING with no reload.
  - Set goes to SETTING.
- ALARM:
  - Any button edge goes to IDLE.
  - Otherwise the alarm counter counts up and returns to IDLE after exactly ALARM_CYCLES cycles in ALARM.
- Output decode:
  - isSetting=1 in SETTING and LOAD.
  - isRunning=1 in RUNNING.
  - alarm=1 in ALARM.
- Strobes:
  - isStarting=1 on the first cycle of every RUNNING entry, from LOAD or from PAUSED.
  - isStopping=1 on the first cycle after leaving RUNNING, whatever the destination.
  - Both strobes are registered.
- Setting digits change only in SETTING. They hold their value in every other state and are not cleared by ALARM.
- Widths:
  - Alarm counter: ceil(log2(ALARM_CYCLES+1)) bits, cleared on every ALARM entry.
  - Guard counter: ceil(log2(GUARD_CYCLES+1)) bits, loaded with GUARD_CYCLES on RUNNING entry and decremented to 0 while in RUNNING.

## Timing
- Reset values:
  - state=IDLE, all setting digits=0, editDigit=0.
  - All outputs 0.
  - Counters 0, all prev registers 1.
- A button edge seen at rising edge N changes state and outputs after edge N. Outputs are visible 1 cycle after the first high sample.
- Start from IDLE or SETTING runs LOAD for 1 cycle (isSetting=1), then RUNNING with isStarting=1 and isRunning=1 together.
- RUNNING→ALARM: alarm=1 and isStopping=1 in the same cycle, 1 cycle after isZero is sampled high.
- isZero is not acted on for GUARD_CYCLES cycles after RUNNING entry. This covers the stale flag left over from before the load.
- Reset asserted mid-operation returns to the reset values asynchronously. No strobe is emitted.

## Test plan
- Reset, then start with all digits zero → state stays IDLE and isStarting never asserts.
- Set, Increment ×7, Digit, Increment ×6 → setting0=7, setting1=0 (wraps after 5), editDigit=1.
- From setting 0,0,0,1, press StartStop → isSetting=1 for 1 cycle, then isStarting=1 for 1 cycle with isRunning=1. isZero=1 held from before is ignored for 2 cycles.
- In RUNNING, press StartStop, then again → isStopping pulse and PAUSED, then isStarting pulse and RUNNING with no isSetting.
- In RUNNING, raise isZero with ALARM_CYCLES=4 → alarm=1 for exactly 4 cycles, then IDLE. Repeat with a Digit press on the 2nd alarm cycle → IDLE on the next cycle.
- Same-cycle Set and StartStop edges in PAUSED → SETTING. Same-cycle isZero and StartStop edge in RUNNING → ALARM.
